sa_result_drain: RTL and testbench

//  Drain end of the systolic array: the counterpart of the operand PIPO feed registers.

---
 rtl/sa_result_drain_if.sv | 28 ++
 rtl/sa_result_drain.sv | 167 ++++++++++++++++
 tb/tb_sa_result_drain.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sa_result_drain_if.sv
// Result stream port of the systolic-array drain: one narrowed column word
// per valid/ready handshake, tagged with its column index and a last flag.
interface sa_result_drain_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 2
);
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;
   logic [IDX_W-1:0]  m_idx;

   modport master (
      output m_data,
      output m_valid,
      input  m_ready,
      output m_last,
      output m_idx
   );

   modport slave (
      input  m_data,
      input  m_valid,
      output m_ready,
      input  m_last,
      input  m_idx
   );
endinterface

// File: rtl/sa_result_drain.sv
// Drain end of the systolic array. On an accepted capture all N column
// accumulators are narrowed to DATA_W bits and stored in parallel, then
// streamed out one word per handshake on the master port of
// sa_result_drain_if. A capture may be taken on the final handshake of the
// previous tile so consecutive tiles stream without a bubble.
//
// Build option RESULT_SAT_EN:
//   defined   - each column is signed-saturated to the DATA_W range
//   undefined - each column is truncated to its low DATA_W bits (wrap)
module sa_result_drain #(
   parameter int N      = 4,
   parameter int ACC_W  = 32,
   parameter int DATA_W = 16,
   localparam int IDX_W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic [N*ACC_W-1:0]   col_data,
   input  logic                 cap,
   output logic                 cap_ready,
   sa_result_drain_if.master    m,
   output logic                 busy,
   output logic                 ovf
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

`ifdef RESULT_SAT_EN
   localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   // Clamp a signed accumulator into the signed DATA_W range. A value fits
   // exactly when sign-extending its low DATA_W bits reproduces it.
   function automatic logic [DATA_W-1:0] sat_narrow(input logic signed [ACC_W-1:0] a);
      logic signed [DATA_W-1:0] lo;
      logic signed [ACC_W-1:0]  back;
      lo   = a[DATA_W-1:0];
      back = ACC_W'(lo);
      if (back == a) begin
         sat_narrow = lo;
      end else if (a[ACC_W-1]) begin
         sat_narrow = SAT_MIN;
      end else begin
         sat_narrow = SAT_MAX;
      end
   endfunction
`else
   // Keep only the low DATA_W bits; out-of-range values wrap.
   function automatic logic [DATA_W-1:0] wrap_narrow(input logic [DATA_W-1:0] a);
      wrap_narrow = a;
   endfunction

   // Upper accumulator bits are intentionally discarded in the wrap build.
   logic unused_hi;
   assign unused_hi = ^col_data;
`endif

   state_e            state_q, state_d;
   logic [DATA_W-1:0] word_q [N];
   logic [DATA_W-1:0] word_d [N];
   logic [DATA_W-1:0] data_q, data_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              ovf_q, ovf_d;

   logic [DATA_W-1:0] narrowed [N];
   logic [IDX_W-1:0]  idx_inc;
   logic              hs;
   logic              cap_rdy;
   logic              cap_ok;

   // Narrow every column in parallel so the whole tile is ready at the accepting edge.
   always_comb begin
      for (int c = 0; c < N; c++) begin
`ifdef RESULT_SAT_EN
         narrowed[c] = sat_narrow(col_data[c*ACC_W +: ACC_W]);
`else
         narrowed[c] = wrap_narrow(col_data[c*ACC_W +: DATA_W]);
`endif
      end
   end

   // Handshake and capture qualification; cap_ready looks through m_ready on the final word.
   always_comb begin
      hs      = valid_q & m.m_ready;
      cap_rdy = (state_q == ST_IDLE) | (hs & last_q);
      cap_ok  = cap & cap_rdy;
      idx_inc = idx_q + IDX_W'(1);
   end

   // Next-state: capture takes priority over advancing, so a capture on the last
   // handshake reloads the buffer and restarts at column 0 with m_valid held high.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      data_d  = data_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      last_d  = last_q;
      ovf_d   = ovf_q;

      if (cap_ok) begin
         state_d = ST_SEND;
         for (int c = 0; c < N; c++) begin
            word_d[c] = narrowed[c];
         end
         data_d  = narrowed[0];
         idx_d   = '0;
         last_d  = 1'b0;
         valid_d = 1'b1;
      end else if (hs) begin
         if (last_q) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
            last_d  = 1'b0;
         end else begin
            idx_d  = idx_inc;
            data_d = word_q[idx_inc];
            last_d = (idx_inc == LAST_IDX);
         end
      end

      // A refused capture leaves buffer and stream alone but is remembered.
      if (cap && !cap_rdy) begin
         ovf_d = 1'b1;
      end
   end

   // State and output registers; reset discards any pending words immediately.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= ST_IDLE;
         for (int c = 0; c < N; c++) begin
            word_q[c] <= '0;
         end
         data_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
      end
   end

   assign cap_ready = cap_rdy;
   assign m.m_data  = data_q;
   assign m.m_valid = valid_q;
   assign m.m_last  = last_q;
   assign m.m_idx   = idx_q;
   assign busy      = (state_q == ST_SEND);
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain (N=4, ACC_W=32, DATA_W=16).
// Inputs change just after the falling edge; outputs are checked there too.
module tb_sa_result_drain;
   localparam int N      = 4;
   localparam int ACC_W  = 32;
   localparam int DATA_W = 16;
   localparam int IDX_W  = 2;

   logic               clk = 1'b0;
   logic               clr_n = 1'b1;
   logic               cap = 1'b0;
   logic [N*ACC_W-1:0] col_data = '0;
   logic               cap_ready;
   logic               busy;
   logic               ovf;

   int n_cmp = 0;
   int n_err = 0;

   sa_result_drain_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) m_if ();

   sa_result_drain #(.N(N), .ACC_W(ACC_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .col_data  (col_data),
      .cap       (cap),
      .cap_ready (cap_ready),
      .m         (m_if),
      .busy      (busy),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load(input logic [31:0] c0, input logic [31:0] c1,
                       input logic [31:0] c2, input logic [31:0] c3);
      col_data = {c3, c2, c1, c0};
   endtask

   task automatic chk_word(input string tag, input logic [31:0] d,
                           input logic [31:0] i, input logic [31:0] l);
      chk({tag, ".valid"}, 32'(m_if.m_valid), 32'd1);
      chk({tag, ".data"},  32'(m_if.m_data),  d);
      chk({tag, ".idx"},   32'(m_if.m_idx),   i);
      chk({tag, ".last"},  32'(m_if.m_last),  l);
   endtask

   logic [31:0] exp_n0, exp_n1;

   initial begin
      m_if.m_ready = 1'b0;

      // 1. async reset with no clock edge
      #1 clr_n = 1'b0;
      #1;
      chk("rst.valid", 32'(m_if.m_valid), 32'd0);
      chk("rst.cap_ready", 32'(cap_ready), 32'd1);
      chk("rst.ovf", 32'(ovf), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.idx", 32'(m_if.m_idx), 32'd0);
      chk("rst.data", 32'(m_if.m_data), 32'd0);
      #1 clr_n = 1'b1;
      tick();

      // 2. streaming with m_ready held high
      load(32'd10, 32'd20, 32'd30, 32'd40);
      cap = 1'b1;
      m_if.m_ready = 1'b1;
      tick();
      cap = 1'b0;
      load(32'd111, 32'd222, 32'd333, 32'd444);
      chk("s2.busy", 32'(busy), 32'd1);
      chk("s2.cap_ready0", 32'(cap_ready), 32'd0);
      for (int k = 0; k < N; k++) begin
         chk_word($sformatf("s2.w%0d", k), 32'(10 * (k + 1)), 32'(k), (k == N - 1) ? 32'd1 : 32'd0);
         if (k == N - 1) chk("s2.cap_ready_last", 32'(cap_ready), 32'd1);
         tick();
      end
      chk("s2.valid_end", 32'(m_if.m_valid), 32'd0);
      chk("s2.busy_end", 32'(busy), 32'd0);

      // 3. backpressure on the first word for three cycles
      load(32'd10, 32'd20, 32'd30, 32'd40);
      cap = 1'b1;
      m_if.m_ready = 1'b0;
      tick();
      cap = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk_word($sformatf("s3.hold%0d", k), 32'd10, 32'd0, 32'd0);
         chk("s3.cap_ready", 32'(cap_ready), 32'd0);
         tick();
      end
      m_if.m_ready = 1'b1;
      chk_word("s3.w0", 32'd10, 32'd0, 32'd0);
      tick();
      for (int k = 1; k < N; k++) begin
         chk_word($sformatf("s3.w%0d", k), 32'(10 * (k + 1)), 32'(k), (k == N - 1) ? 32'd1 : 32'd0);
         tick();
      end
      chk("s3.valid_end", 32'(m_if.m_valid), 32'd0);

      // 4a. capture refused mid-stream
      load(32'd10, 32'd20, 32'd30, 32'd40);
      cap = 1'b1;
      tick();
      cap = 1'b0;
      chk_word("s4.w0", 32'd10, 32'd0, 32'd0);
      tick();
      chk_word("s4.w1", 32'd20, 32'd1, 32'd0);
      load(32'd99, 32'd99, 32'd99, 32'd99);
      cap = 1'b1;
      tick();
      cap = 1'b0;
      chk("s4.ovf", 32'(ovf), 32'd1);
      chk_word("s4.w2", 32'd30, 32'd2, 32'd0);
      tick();
      chk_word("s4.w3", 32'd40, 32'd3, 32'd1);

      // 4b. back-to-back capture on the final handshake
      load(32'd5, 32'd6, 32'd7, 32'd8);
      cap = 1'b1;
      chk("s4.b2b_cap_ready", 32'(cap_ready), 32'd1);
      tick();
      cap = 1'b0;
      for (int k = 0; k < N; k++) begin
         chk_word($sformatf("s4.b2b%0d", k), 32'(5 + k), 32'(k), (k == N - 1) ? 32'd1 : 32'd0);
         tick();
      end
      chk("s4.valid_end", 32'(m_if.m_valid), 32'd0);
      chk("s4.ovf_sticky", 32'(ovf), 32'd1);

      // 5. narrowing at the range boundaries
`ifdef RESULT_SAT_EN
      exp_n0 = 32'h7FFF;
      exp_n1 = 32'h8000;
`else
      exp_n0 = 32'h0000;
      exp_n1 = 32'h63C0;
`endif
      load(32'h0001_0000, 32'hFFFF_63C0, 32'hFFFF_8000, 32'h0000_7FFF);
      cap = 1'b1;
      tick();
      cap = 1'b0;
      chk_word("s5.c0", exp_n0, 32'd0, 32'd0);
      tick();
      chk_word("s5.c1", exp_n1, 32'd1, 32'd0);
      tick();
      chk_word("s5.c2", 32'h8000, 32'd2, 32'd0);
      tick();
      chk_word("s5.c3", 32'h7FFF, 32'd3, 32'd1);
      tick();

      // 6. reset in the middle of a stream
      load(32'd10, 32'd20, 32'd30, 32'd40);
      cap = 1'b1;
      tick();
      cap = 1'b0;
      tick();
      tick();
      chk_word("s6.w2", 32'd30, 32'd2, 32'd0);
      #1 clr_n = 1'b0;
      #1;
      chk("s6.rst_valid", 32'(m_if.m_valid), 32'd0);
      chk("s6.rst_idx", 32'(m_if.m_idx), 32'd0);
      chk("s6.rst_busy", 32'(busy), 32'd0);
      chk("s6.rst_ovf", 32'(ovf), 32'd0);
      #1 clr_n = 1'b1;
      chk("s6.cap_ready", 32'(cap_ready), 32'd1);
      load(32'd1, 32'd2, 32'd3, 32'd4);
      cap = 1'b1;
      tick();
      cap = 1'b0;
      for (int k = 0; k < N; k++) begin
         chk_word($sformatf("s6.new%0d", k), 32'(k + 1), 32'(k), (k == N - 1) ? 32'd1 : 32'd0);
         tick();
      end
      chk("s6.valid_end", 32'(m_if.m_valid), 32'd0);
      chk("s6.ovf_end", 32'(ovf), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
